// File: rtl/psum_scratch_arbiter_pkg.sv
// Shared types, requester indices and saturation limits for the psum scratchpad arbiter.
package psum_scratch_arbiter_pkg;

   localparam int unsigned NumReq = 3;
   localparam int unsigned ReqPe  = 0;
   localparam int unsigned ReqAdd = 1;
   localparam int unsigned ReqRd  = 2;

   localparam int unsigned ScratchWidth = 16;
   localparam logic [ScratchWidth-1:0] SatMax = {1'b0, {(ScratchWidth-1){1'b1}}};
   localparam logic [ScratchWidth-1:0] SatMin = {1'b1, {(ScratchWidth-1){1'b0}}};

   typedef enum logic {StIdle, StRmwWr} state_e;

   // Next requester in round-robin order, wrapping 2 -> 0.
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/psum_scratch_arbiter_if.sv
// Requester and scratchpad bus of the psum arbiter; slave is the arbiter side.
interface psum_scratch_arbiter_if
   import psum_scratch_arbiter_pkg::*;
#(
   parameter int unsigned SCRATCH_DEPTH = 16,
   parameter int unsigned SCRATCH_WIDTH = 16
);
   localparam int unsigned AddrW = $clog2(SCRATCH_DEPTH);

   logic [NumReq-1:0]               req;
   logic [NumReq-1:0]               acc;
   logic [NumReq-1:0]               we;
   logic [NumReq*AddrW-1:0]         addr_i;
   logic [NumReq*SCRATCH_WIDTH-1:0] wdata_i;
   logic                            sat_clr;
   logic [NumReq-1:0]               gnt;
   logic                            rvalid;
   logic [1:0]                      rid;
   logic [SCRATCH_WIDTH-1:0]        rdata_o;
   logic                            sp_ren;
   logic                            sp_wen;
   logic [AddrW-1:0]                sp_addr;
   logic [SCRATCH_WIDTH-1:0]        sp_wdata;
   logic [SCRATCH_WIDTH-1:0]        sp_rdata;
   logic                            busy;
   logic                            sat_flag;

   modport master (
      output req, acc, we, addr_i, wdata_i, sat_clr, sp_rdata,
      input  gnt, rvalid, rid, rdata_o, sp_ren, sp_wen, sp_addr, sp_wdata, busy, sat_flag
   );

   modport slave (
      input  req, acc, we, addr_i, wdata_i, sat_clr, sp_rdata,
      output gnt, rvalid, rid, rdata_o, sp_ren, sp_wen, sp_addr, sp_wdata, busy, sat_flag
   );

endinterface

// File: rtl/psum_scratch_arbiter_rr_arbiter3.sv
// rr_arbiter3: combinational 3-way round-robin picker with its registered priority pointer.
module psum_scratch_arbiter_rr_arbiter3
   import psum_scratch_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NumReq-1:0] req_i,
   input  logic              en_i,
   output logic [NumReq-1:0] gnt_o,
   output logic [1:0]        win_o,
   output logic              valid_o
);

   logic [1:0] ptr_q;
   logic [1:0] idx;

   always_comb begin
      idx     = ptr_q;
      win_o   = 2'd0;
      valid_o = 1'b0;
      for (int k = 0; k < NumReq; k++) begin
         if (!valid_o && req_i[idx]) begin
            valid_o = 1'b1;
            win_o   = idx;
         end
         idx = rr_next(idx);
      end
      gnt_o = (en_i && valid_o) ? (3'b001 << win_o) : 3'b000;
   end

   // Pointer only moves on an actual grant, so idle cycles and RMW_WR leave it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 2'd0;
      end else if (en_i && valid_o) begin
         ptr_q <= rr_next(win_o);
      end
   end

endmodule

// File: rtl/psum_scratch_arbiter.sv
// Round-robin arbiter/sequencer for the single-port psum scratchpad: plain reads and writes,
// plus two-cycle saturating read-modify-write accumulates.
module psum_scratch_arbiter
   import psum_scratch_arbiter_pkg::*;
#(
   parameter int unsigned SCRATCH_DEPTH = 16,
   parameter int unsigned SCRATCH_WIDTH = ScratchWidth
) (
   input logic                   clk,
   input logic                   rst_n,
   psum_scratch_arbiter_if.slave bus
);

   localparam int unsigned AddrW = $clog2(SCRATCH_DEPTH);
   localparam int unsigned W     = SCRATCH_WIDTH;
   localparam logic [W-1:0] SatHi = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SatLo = {1'b1, {(W-1){1'b0}}};

   state_e           state_q;
   logic [AddrW-1:0] rmw_addr_q;
   logic [W-1:0]     addend_q;
   logic             rvalid_q;
   logic [1:0]       rid_q;
   logic             sat_flag_q;

   logic             grant_en;
   logic             any_req;
   logic             issue;
   logic [1:0]       win;
   logic             win_acc;
   logic             win_we;
   logic [AddrW-1:0] win_addr;
   logic [W-1:0]     win_wdata;
   logic [W:0]       sum_ext;
   logic             sat_ovf;
   logic             sat_now;
   logic [W-1:0]     sat_wdata;

   assign grant_en = (state_q == StIdle);

   psum_scratch_arbiter_rr_arbiter3 u_rr_arbiter3 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   (bus.req),
      .en_i    (grant_en),
      .gnt_o   (bus.gnt),
      .win_o   (win),
      .valid_o (any_req)
   );

   assign issue     = grant_en && any_req;
   assign win_acc   = bus.acc[win];
   assign win_we    = bus.we[win];
   assign win_addr  = bus.addr_i[32'(win)*AddrW +: AddrW];
   assign win_wdata = bus.wdata_i[32'(win)*W +: W];

   // One extra bit of headroom; the top two bits disagree exactly on overflow.
   assign sum_ext   = {bus.sp_rdata[W-1], bus.sp_rdata} + {addend_q[W-1], addend_q};
   assign sat_ovf   = sum_ext[W] ^ sum_ext[W-1];
   assign sat_wdata = sat_ovf ? (sum_ext[W] ? SatLo : SatHi) : sum_ext[W-1:0];
   assign sat_now   = (state_q == StRmwWr) && sat_ovf;

   always_comb begin
      bus.sp_ren   = 1'b0;
      bus.sp_wen   = 1'b0;
      bus.sp_addr  = '0;
      bus.sp_wdata = '0;
      if (state_q == StRmwWr) begin
         bus.sp_wen   = 1'b1;
         bus.sp_addr  = rmw_addr_q;
         bus.sp_wdata = sat_wdata;
      end else if (any_req) begin
         bus.sp_addr = win_addr;
         if (win_acc || !win_we) begin
            bus.sp_ren = 1'b1;
         end else begin
            bus.sp_wen   = 1'b1;
            bus.sp_wdata = win_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rmw_addr_q <= '0;
         addend_q   <= '0;
         rvalid_q   <= 1'b0;
         rid_q      <= 2'd0;
         sat_flag_q <= 1'b0;
      end else begin
         rvalid_q <= issue && !win_acc && !win_we;
         if (issue) begin
            rid_q <= win;
         end
         // A saturation in the same cycle as sat_clr keeps the flag set.
         if (sat_now) begin
            sat_flag_q <= 1'b1;
         end else if (bus.sat_clr) begin
            sat_flag_q <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               if (issue && win_acc) begin
                  state_q    <= StRmwWr;
                  rmw_addr_q <= win_addr;
                  addend_q   <= win_wdata;
               end
            end
            StRmwWr: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy     = (state_q == StRmwWr);
   assign bus.rvalid   = rvalid_q;
   assign bus.rid      = rid_q;
   assign bus.rdata_o  = rvalid_q ? bus.sp_rdata : '0;
   assign bus.sat_flag = sat_flag_q;

endmodule

// File: tb/tb_psum_scratch_arbiter.sv
// Self-checking bench for psum_scratch_arbiter: directed sequences, an accumulate vector table
// and a randomized run against a transaction-level scratchpad model.
module tb_psum_scratch_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   logic mem_clear = 1'b0;

   always #5 clk = ~clk;

   psum_scratch_arbiter_if #(.SCRATCH_DEPTH(16), .SCRATCH_WIDTH(16)) bus ();

   psum_scratch_arbiter #(.SCRATCH_DEPTH(16), .SCRATCH_WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Scratchpad: registered read data, one access per cycle.
   logic [15:0] mem [16];
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 16; i++) mem[i] <= 16'd0;
      end else if (bus.sp_wen) begin
         mem[bus.sp_addr] <= bus.sp_wdata;
      end
      if (bus.sp_ren) bus.sp_rdata <= mem[bus.sp_addr];
   end

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void check(input string name, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic r, input logic a, input logic w,
                          input logic [3:0] ad, input logic [15:0] d);
      bus.req[i]              = r;
      bus.acc[i]              = a;
      bus.we[i]               = w;
      bus.addr_i[i*4 +: 4]    = ad;
      bus.wdata_i[i*16 +: 16] = d;
   endtask

   task automatic bus_idle();
      bus.req     = '0;
      bus.acc     = '0;
      bus.we      = '0;
      bus.addr_i  = '0;
      bus.wdata_i = '0;
      bus.sat_clr = 1'b0;
   endtask

   task automatic do_reset(input bit clear);
      bus_idle();
      rst_n     = 1'b0;
      mem_clear = clear;
      tick();
      tick();
      mem_clear = 1'b0;
      rst_n     = 1'b1;
   endtask

   task automatic wr(input int i, input logic [3:0] a, input logic [15:0] d);
      set_req(i, 1'b1, 1'b0, 1'b1, a, d);
      tick();
      bus.req[i] = 1'b0;
   endtask

   typedef struct {
      int stored;
      int addend;
      int exp_wr;
      bit exp_sat;
      bit clr_rmw;
   } acc_vec_t;

   acc_vec_t vecs[7];

   // Random-phase requester state and reference model
   logic        r_req  [3];
   logic        r_acc  [3];
   logic        r_we   [3];
   logic [3:0]  r_addr [3];
   logic [15:0] r_data [3];
   int ref_mem [16];
   int m_ptr, m_a, m_d, m_rdid, m_rdval;
   bit m_rmw, m_rdv, m_sat;

   initial begin
      #400000;
      $display("FAIL watchdog: got time limit, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, s, kind;
      bit sat_now;

      vecs[0] = '{10, 3, 13, 1'b0, 1'b1};
      vecs[1] = '{32760, 100, 32767, 1'b1, 1'b0};
      vecs[2] = '{-32760, -100, -32768, 1'b1, 1'b0};
      vecs[3] = '{-5, 7, 2, 1'b0, 1'b0};
      vecs[4] = '{32767, -1, 32766, 1'b0, 1'b0};
      vecs[5] = '{-32768, -1, -32768, 1'b1, 1'b1};
      vecs[6] = '{100, -200, -100, 1'b0, 1'b0};

      // Reset values
      bus_idle();
      rst_n     = 1'b0;
      mem_clear = 1'b1;
      #3;
      check("rst_gnt", int'(bus.gnt), 0);
      check("rst_rvalid", int'(bus.rvalid), 0);
      check("rst_rid", int'(bus.rid), 0);
      check("rst_rdata", int'(bus.rdata_o), 0);
      check("rst_sp_ren", int'(bus.sp_ren), 0);
      check("rst_sp_wen", int'(bus.sp_wen), 0);
      check("rst_sp_addr", int'(bus.sp_addr), 0);
      check("rst_sp_wdata", int'(bus.sp_wdata), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_sat_flag", int'(bus.sat_flag), 0);
      tick();
      tick();
      mem_clear = 1'b0;
      rst_n     = 1'b1;

      // Three simultaneous reads after reset: grants 0,1,2 in order
      wr(0, 4'd1, 16'd11);
      wr(0, 4'd2, 16'd22);
      wr(0, 4'd3, 16'd33);
      do_reset(1'b0);
      set_req(0, 1'b1, 1'b0, 1'b0, 4'd1, 16'd0);
      set_req(1, 1'b1, 1'b0, 1'b0, 4'd2, 16'd0);
      set_req(2, 1'b1, 1'b0, 1'b0, 4'd3, 16'd0);
      @(negedge clk);
      check("rr_gnt0", int'(bus.gnt), 1);
      check("rr_ren0", int'(bus.sp_ren), 1);
      check("rr_addr0", int'(bus.sp_addr), 1);
      check("rr_rvalid_early", int'(bus.rvalid), 0);
      tick();
      bus.req[0] = 1'b0;
      @(negedge clk);
      check("rr_gnt1", int'(bus.gnt), 2);
      check("rr_addr1", int'(bus.sp_addr), 2);
      check("rr_rvalid0", int'(bus.rvalid), 1);
      check("rr_rid0", int'(bus.rid), 0);
      check("rr_rdata0", int'(bus.rdata_o), 11);
      tick();
      bus.req[1] = 1'b0;
      @(negedge clk);
      check("rr_gnt2", int'(bus.gnt), 4);
      check("rr_rid1", int'(bus.rid), 1);
      check("rr_rdata1", int'(bus.rdata_o), 22);
      tick();
      bus.req[2] = 1'b0;
      @(negedge clk);
      check("rr_gnt_none", int'(bus.gnt), 0);
      check("rr_rvalid2", int'(bus.rvalid), 1);
      check("rr_rid2", int'(bus.rid), 2);
      check("rr_rdata2", int'(bus.rdata_o), 33);
      tick();

      // Write then read of the same address
      set_req(0, 1'b1, 1'b0, 1'b1, 4'd4, 16'd5);
      @(negedge clk);
      check("wr_gnt", int'(bus.gnt), 1);
      check("wr_wen", int'(bus.sp_wen), 1);
      check("wr_addr", int'(bus.sp_addr), 4);
      check("wr_wdata", int'(bus.sp_wdata), 5);
      tick();
      bus.req[0] = 1'b0;
      set_req(2, 1'b1, 1'b0, 1'b0, 4'd4, 16'd0);
      @(negedge clk);
      check("wr_rd_gnt", int'(bus.gnt), 4);
      tick();
      bus.req[2] = 1'b0;
      @(negedge clk);
      check("wr_rd_rvalid", int'(bus.rvalid), 1);
      check("wr_rd_rid", int'(bus.rid), 2);
      check("wr_rd_rdata", int'(bus.rdata_o), 5);
      tick();

      // Accumulate with another requester pending: it waits out RMW_WR
      wr(2, 4'd7, 16'd10);
      set_req(0, 1'b1, 1'b1, 1'b0, 4'd7, 16'd3);
      set_req(1, 1'b1, 1'b0, 1'b0, 4'd7, 16'd0);
      @(negedge clk);
      check("rmw_gnt", int'(bus.gnt), 1);
      check("rmw_ren", int'(bus.sp_ren), 1);
      check("rmw_busy0", int'(bus.busy), 0);
      tick();
      bus.req[0] = 1'b0;
      @(negedge clk);
      check("rmw_busy1", int'(bus.busy), 1);
      check("rmw_gnt_held", int'(bus.gnt), 0);
      check("rmw_wen", int'(bus.sp_wen), 1);
      check("rmw_addr", int'(bus.sp_addr), 7);
      check("rmw_wdata", int'($signed(bus.sp_wdata)), 13);
      tick();
      @(negedge clk);
      check("rmw_busy2", int'(bus.busy), 0);
      check("rmw_gnt1", int'(bus.gnt), 2);
      tick();
      bus.req[1] = 1'b0;
      @(negedge clk);
      check("rmw_rd_rdata", int'(bus.rdata_o), 13);
      check("rmw_rd_rid", int'(bus.rid), 1);
      check("rmw_sat", int'(bus.sat_flag), 0);
      tick();

      // Back-to-back accumulates of +1 at addr 0
      set_req(0, 1'b1, 1'b1, 1'b0, 4'd0, 16'd1);
      @(negedge clk);
      check("b2b_gnt_a", int'(bus.gnt), 1);
      tick();
      @(negedge clk);
      check("b2b_busy_a", int'(bus.busy), 1);
      check("b2b_gnt_wait", int'(bus.gnt), 0);
      check("b2b_wdata_a", int'($signed(bus.sp_wdata)), 1);
      tick();
      @(negedge clk);
      check("b2b_gnt_b", int'(bus.gnt), 1);
      tick();
      bus.req[0] = 1'b0;
      @(negedge clk);
      check("b2b_wdata_b", int'($signed(bus.sp_wdata)), 2);
      tick();
      set_req(2, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
      tick();
      bus.req[2] = 1'b0;
      @(negedge clk);
      check("b2b_rdata", int'(bus.rdata_o), 2);
      tick();

      // Accumulate vector table
      foreach (vecs[v]) begin
         bus.sat_clr = 1'b1;
         wr(0, 4'd9, 16'(vecs[v].stored));
         bus.sat_clr = 1'b0;
         set_req(1, 1'b1, 1'b1, 1'b0, 4'd9, 16'(vecs[v].addend));
         @(negedge clk);
         check($sformatf("vec%0d_clr", v), int'(bus.sat_flag), 0);
         check($sformatf("vec%0d_gnt", v), int'(bus.gnt), 2);
         tick();
         bus.req[1]  = 1'b0;
         bus.sat_clr = vecs[v].clr_rmw;
         @(negedge clk);
         check($sformatf("vec%0d_wen", v), int'(bus.sp_wen), 1);
         check($sformatf("vec%0d_wdata", v), int'($signed(bus.sp_wdata)), vecs[v].exp_wr);
         tick();
         bus.sat_clr = 1'b0;
         set_req(2, 1'b1, 1'b0, 1'b0, 4'd9, 16'd0);
         @(negedge clk);
         check($sformatf("vec%0d_sat", v), int'(bus.sat_flag), int'(vecs[v].exp_sat));
         tick();
         bus.req[2] = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d_rdata", v), int'($signed(bus.rdata_o)), vecs[v].exp_wr);
         tick();
      end

      // Reset during RMW_WR drops the write; afterwards priority restarts at 0
      do_reset(1'b1);
      set_req(0, 1'b1, 1'b1, 1'b0, 4'd5, 16'd9);
      @(negedge clk);
      check("rstrmw_gnt", int'(bus.gnt), 1);
      tick();
      check("rstrmw_busy_pre", int'(bus.busy), 1);
      bus_idle();
      rst_n = 1'b0;
      #1;
      check("rstrmw_busy", int'(bus.busy), 0);
      check("rstrmw_wen", int'(bus.sp_wen), 0);
      check("rstrmw_wdata", int'(bus.sp_wdata), 0);
      check("rstrmw_addr", int'(bus.sp_addr), 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 1'b0, 4'd5, 16'd0);
      @(negedge clk);
      check("rstrmw_gnt0", int'(bus.gnt), 1);
      tick();
      bus.req[0] = 1'b0;
      @(negedge clk);
      check("rstrmw_gnt1", int'(bus.gnt), 2);
      check("rstrmw_rdata", int'(bus.rdata_o), 0);
      tick();
      bus.req[1] = 1'b0;
      @(negedge clk);
      check("rstrmw_gnt2", int'(bus.gnt), 4);
      tick();
      bus.req[2] = 1'b0;
      @(negedge clk);
      check("rstrd_rvalid_pre", int'(bus.rvalid), 1);
      rst_n = 1'b0;
      #1;
      check("rstrd_rvalid", int'(bus.rvalid), 0);
      check("rstrd_rid", int'(bus.rid), 0);
      tick();
      rst_n = 1'b1;

      // Randomized traffic against the reference model
      do_reset(1'b1);
      for (int i = 0; i < 16; i++) ref_mem[i] = 0;
      for (int i = 0; i < 3; i++) r_req[i] = 1'b0;
      m_ptr = 0;
      m_rmw = 1'b0;
      m_rdv = 1'b0;
      m_sat = 1'b0;
      m_a = 0;
      m_d = 0;
      m_rdid = 0;
      m_rdval = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int i = 0; i < 3; i++) begin
            if (!r_req[i] && ($urandom_range(0, 1) == 1)) begin
               kind      = int'($urandom_range(0, 3));
               r_req[i]  = 1'b1;
               r_acc[i]  = (kind >= 2);
               r_we[i]   = (kind == 1) || (r_acc[i] && $urandom_range(0, 1) == 1);
               r_addr[i] = 4'($urandom_range(0, 3));
               r_data[i] = ($urandom_range(0, 1) == 1) ? 16'(int'($urandom_range(0, 40)) - 20)
                                                       : 16'($urandom);
            end
            set_req(i, r_req[i], r_acc[i], r_we[i], r_addr[i], r_data[i]);
         end
         bus.sat_clr = ($urandom_range(0, 7) == 0);
         w = -1;
         if (!m_rmw) begin
            for (int k = 0; k < 3; k++) begin
               if (w < 0 && r_req[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
            end
         end
         @(negedge clk);
         check("rnd_gnt", int'(bus.gnt), (w < 0) ? 0 : (1 << w));
         check("rnd_busy", int'(bus.busy), int'(m_rmw));
         check("rnd_rvalid", int'(bus.rvalid), int'(m_rdv));
         if (m_rdv) begin
            check("rnd_rdata", int'($signed(bus.rdata_o)), m_rdval);
            check("rnd_rid", int'(bus.rid), m_rdid);
         end
         check("rnd_sat_flag", int'(bus.sat_flag), int'(m_sat));
         sat_now = 1'b0;
         if (m_rmw) begin
            s = ref_mem[m_a] + m_d;
            if (s > 32767) begin
               s = 32767;
               sat_now = 1'b1;
            end else if (s < -32768) begin
               s = -32768;
               sat_now = 1'b1;
            end
            check("rnd_rmw_wdata", int'($signed(bus.sp_wdata)), s);
            ref_mem[m_a] = s;
            m_rmw = 1'b0;
         end
         if (sat_now) m_sat = 1'b1;
         else if (bus.sat_clr) m_sat = 1'b0;
         m_rdv = 1'b0;
         if (w >= 0) begin
            m_ptr = (w + 1) % 3;
            if (r_acc[w]) begin
               m_rmw = 1'b1;
               m_a   = int'(r_addr[w]);
               m_d   = int'($signed(r_data[w]));
            end else if (r_we[w]) begin
               ref_mem[r_addr[w]] = int'($signed(r_data[w]));
            end else begin
               m_rdv   = 1'b1;
               m_rdid  = w;
               m_rdval = ref_mem[r_addr[w]];
            end
            r_req[w] = 1'b0;
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
